// File: rtl/line_clear_engine.sv
// Line-clear engine: scans the playfield bottom-up, drops full rows, compacts and zero-fills the top.
// Optional LCE_SCORE_EN adds a saturating 16-bit score output that accumulates across runs.
module line_clear_engine #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [4:0] lines_cleared,
    output logic       brd_we,
    output logic [3:0] brd_wx,
    output logic [4:0] brd_wy,
    output logic       brd_wdata,
    output logic [3:0] brd_rx,
    output logic [4:0] brd_ry,
    input  logic       brd_rdata
`ifdef LCE_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [3:0] LAST_COL = 4'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EVAL,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [4:0]      r_src;
    logic [4:0]      r_dst;
    logic [3:0]      r_col;
    logic [4:0]      r_cnt;
    logic [4:0]      r_lines;
    logic [COLS-1:0] r_rowbuf;

    logic w_colLast;
    logic w_rowFull;
    logic w_srcTop;
    logic w_dstTop;

    assign w_colLast = (r_col == LAST_COL);
    assign w_rowFull = &r_rowbuf;
    assign w_srcTop  = (r_src == 5'd0);
    assign w_dstTop  = (r_dst == 5'd0);

    // dst never drops below src, so each row is read before anything overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_src    <= LAST_ROW;
            r_dst    <= LAST_ROW;
            r_col    <= 4'd0;
            r_cnt    <= 5'd0;
            r_lines  <= 5'd0;
            r_rowbuf <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src   <= LAST_ROW;
                        r_dst   <= LAST_ROW;
                        r_col   <= 4'd0;
                        r_cnt   <= 5'd0;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    r_rowbuf[r_col] <= brd_rdata;
                    if (w_colLast) begin
                        r_col   <= 4'd0;
                        r_state <= S_EVAL;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                S_EVAL: begin
                    if (w_rowFull) begin
                        r_cnt   <= r_cnt + 5'd1;
                        r_src   <= r_src - 5'd1;
                        r_state <= w_srcTop ? S_CLEAR : S_READ;
                    end else if (r_src != r_dst) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_src <= r_src - 5'd1;
                        r_dst <= r_dst - 5'd1;
                        if (w_srcTop)
                            r_state <= (r_cnt != 5'd0) ? S_CLEAR : S_DONE;
                        else
                            r_state <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_colLast) begin
                        r_col <= 4'd0;
                        r_src <= r_src - 5'd1;
                        r_dst <= r_dst - 5'd1;
                        if (w_srcTop)
                            r_state <= (r_cnt != 5'd0) ? S_CLEAR : S_DONE;
                        else
                            r_state <= S_READ;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                S_CLEAR: begin
                    if (w_colLast) begin
                        r_col <= 4'd0;
                        if (w_dstTop)
                            r_state <= S_DONE;
                        else
                            r_dst <= r_dst - 5'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end
                S_DONE: begin
                    r_lines <= r_cnt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Status and store strobes decode straight from state, so reset drops them without a clock.
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign brd_we        = (r_state == S_WRITE) || (r_state == S_CLEAR);
    assign brd_wdata     = (r_state == S_WRITE) && r_rowbuf[r_col];
    assign brd_wx        = r_col;
    assign brd_rx        = r_col;
    assign brd_wy        = brd_we ? r_dst : 5'd0;
    assign brd_ry        = (r_state == S_READ) ? r_src : 5'd0;
    assign lines_cleared = r_lines;

`ifdef LCE_SCORE_EN
    logic [15:0] r_score;
    logic [15:0] w_scoreInc;
    logic [16:0] w_scoreSum;

    always_comb begin
        w_scoreInc = 16'd0;
        case (r_cnt)
            5'd0:    w_scoreInc = 16'd0;
            5'd1:    w_scoreInc = 16'd40;
            5'd2:    w_scoreInc = 16'd100;
            5'd3:    w_scoreInc = 16'd300;
            default: w_scoreInc = 16'd1200;
        endcase
    end

    assign w_scoreSum = {1'b0, r_score} + {1'b0, w_scoreInc};

    // Score survives between runs and saturates rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_score <= 16'd0;
        else if (r_state == S_DONE)
            r_score <= w_scoreSum[16] ? 16'hFFFF : w_scoreSum[15:0];
    end

    assign score = r_score;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: behavioural 10x20 board store plus hand-computed results.
// Checks latency, final board contents, lines_cleared, restart-while-busy and mid-run reset.
module tb_line_clear_engine;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [4:0] linesCleared;
    logic       brdWe;
    logic [3:0] brdWx;
    logic [4:0] brdWy;
    logic       brdWdata;
    logic [3:0] brdRx;
    logic [4:0] brdRy;
    logic       brdRdata;
`ifdef LCE_SCORE_EN
    logic [15:0] score;
`endif

    logic [COLS-1:0] board       [ROWS];
    logic [COLS-1:0] presetBoard [ROWS];
    logic [COLS-1:0] expBoard    [ROWS];
    logic            tbLoad;

    int checks;
    int errors;
    int weCount;
    int doneCount;

    line_clear_engine #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (linesCleared),
        .brd_we        (brdWe),
        .brd_wx        (brdWx),
        .brd_wy        (brdWy),
        .brd_wdata     (brdWdata),
        .brd_rx        (brdRx),
        .brd_ry        (brdRy),
        .brd_rdata     (brdRdata)
`ifdef LCE_SCORE_EN
        ,
        .score         (score)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Board store: combinational read, write at the clock edge; tbLoad preloads a whole board.
    always_comb begin
        brdRdata = 1'b0;
        if (int'(brdRy) < ROWS && int'(brdRx) < COLS)
            brdRdata = board[int'(brdRy)][int'(brdRx)];
    end

    always @(posedge clk) begin
        if (tbLoad) begin
            for (int r = 0; r < ROWS; r++)
                board[r] <= presetBoard[r];
        end else if (brdWe === 1'b1 && int'(brdWy) < ROWS && int'(brdWx) < COLS) begin
            board[int'(brdWy)][int'(brdWx)] <= brdWdata;
        end
    end

    always @(negedge clk) begin
        if (brdWe === 1'b1) weCount++;
        if (done === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearTables();
        for (int r = 0; r < ROWS; r++) begin
            presetBoard[r] = '0;
            expBoard[r]    = '0;
        end
    endtask

    task automatic loadBoard();
        @(negedge clk);
        tbLoad = 1'b1;
        @(negedge clk);
        tbLoad = 1'b0;
    endtask

    task automatic checkBoard(input string tag);
        for (int r = 0; r < ROWS; r++)
            checkOutput($sformatf("%s_row%0d", tag, r), 32'(board[r]), 32'(expBoard[r]));
    endtask

    // Pulses start, optionally re-pulses it at cycle extraStartAt, returns cycles until done (-1 on timeout).
    task automatic applyStimulus(input int extraStartAt, output int latency);
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        while (!seen && cycles < 2000) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == extraStartAt);
            if (done === 1'b1) seen = 1'b1;
        end
        start   = 1'b0;
        latency = seen ? cycles : -1;
        @(posedge clk);
        #1;
    endtask

    task automatic setLinesPattern();
        clearTables();
        presetBoard[19] = 10'b1111111111;
        presetBoard[18] = 10'b0000001000;
        expBoard[19]    = 10'b0000001000;
    endtask

    initial begin
        int latency;
        int weBefore;
        int doneBefore;
        int bound;

        checks    = 0;
        errors    = 0;
        weCount   = 0;
        doneCount = 0;
        reset     = 1'b1;
        start     = 1'b0;
        tbLoad    = 1'b0;
        clearTables();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_we", 32'(brdWe), 32'd0);
        checkOutput("rst_lines", 32'(linesCleared), 32'd0);
        checkOutput("rst_ry", 32'(brdRy), 32'd0);
        checkOutput("rst_wy", 32'(brdWy), 32'd0);
        checkOutput("rst_rx", 32'(brdRx), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Empty board: no writes, 1 + 20*11 cycles.
        loadBoard();
        weBefore   = weCount;
        doneBefore = doneCount;
        applyStimulus(0, latency);
        checkOutput("empty_latency", 32'(latency), 32'd221);
        checkOutput("empty_we", 32'(weCount - weBefore), 32'd0);
        checkOutput("empty_donepulses", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("empty_lines", 32'(linesCleared), 32'd0);
        checkOutput("empty_busy", 32'(busy), 32'd0);
        checkBoard("empty");

        // Four full rows with one cell above: 16 moved rows, 4 cleared.
        clearTables();
        for (int r = 16; r < 20; r++) presetBoard[r] = 10'b1111111111;
        presetBoard[15] = 10'b0000000001;
        expBoard[19]    = 10'b0000000001;
        loadBoard();
        applyStimulus(0, latency);
        checkOutput("tetris_latency", 32'(latency), 32'd421);
        checkOutput("tetris_lines", 32'(linesCleared), 32'd4);
        checkBoard("tetris");
`ifdef LCE_SCORE_EN
        checkOutput("tetris_score", 32'(score), 32'd1200);
`endif

        // Single full bottom row with col 3 above it.
        setLinesPattern();
        loadBoard();
        applyStimulus(0, latency);
        checkOutput("single_latency", 32'(latency), 32'd421);
        checkOutput("single_lines", 32'(linesCleared), 32'd1);
        checkBoard("single");

        // Only row 0 full: nothing moves, row 0 cleared in place.
        clearTables();
        presetBoard[0]  = 10'b1111111111;
        presetBoard[5]  = 10'b1010101010;
        presetBoard[19] = 10'b0111111111;
        expBoard[5]     = 10'b1010101010;
        expBoard[19]    = 10'b0111111111;
        loadBoard();
        applyStimulus(0, latency);
        checkOutput("top_latency", 32'(latency), 32'd231);
        checkOutput("top_lines", 32'(linesCleared), 32'd1);
        checkBoard("top");

        // Second start pulse while busy must be ignored.
        setLinesPattern();
        loadBoard();
        doneBefore = doneCount;
        applyStimulus(50, latency);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("restart_latency", 32'(latency), 32'd421);
        checkOutput("restart_donepulses", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("restart_busy", 32'(busy), 32'd0);
        checkOutput("restart_lines", 32'(linesCleared), 32'd1);
        checkBoard("restart");

        // Reset asserted mid-cycle while WRITE is active.
        setLinesPattern();
        loadBoard();
        doneBefore = doneCount;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bound = 0;
        while (brdWe !== 1'b1 && bound < 500) begin
            @(posedge clk);
            #1;
            bound++;
        end
        checkOutput("abort_reached_write", 32'(brdWe), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_we", 32'(brdWe), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        checkOutput("abort_donepulses", 32'(doneCount - doneBefore), 32'd0);

        setLinesPattern();
        loadBoard();
        applyStimulus(0, latency);
        checkOutput("rerun_latency", 32'(latency), 32'd421);
        checkOutput("rerun_lines", 32'(linesCleared), 32'd1);
        checkBoard("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
